// File: rtl/audio_input.sv
// rtl/audio_input.sv - stereo 1-bit delta-sigma decimator feeding a 32-bit word FIFO
// Optional macro AUDIO_INPUT_SYNC_EN inserts a two-flop synchronizer on ext_audio_r/ext_audio_l.
module audio_input #(
  parameter int DECIMATION_LOG2    = 8,
  parameter int FIFO_DEPTH_IN_BITS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        ext_audio_r,
  input  logic                        ext_audio_l,
  input  logic                        req_toggle,
  output logic [31:0]                 data,
  output logic                        empty,
  output logic [FIFO_DEPTH_IN_BITS:0] level,
  output logic                        overrun,
  input  logic                        overrun_clear
);

  localparam int DEPTH = 1 << FIFO_DEPTH_IN_BITS;
  localparam int SHIFT = 16 - DECIMATION_LOG2;
  localparam logic [FIFO_DEPTH_IN_BITS:0] FULL_LEVEL = {1'b1, {FIFO_DEPTH_IN_BITS{1'b0}}};
  localparam logic [FIFO_DEPTH_IN_BITS:0] LEVEL_ONE = (FIFO_DEPTH_IN_BITS+1)'(1);
  localparam logic [FIFO_DEPTH_IN_BITS-1:0] PTR_ONE = FIFO_DEPTH_IN_BITS'(1);
  localparam logic [DECIMATION_LOG2-1:0] PHASE_ONE = DECIMATION_LOG2'(1);

  logic src_r, src_l;
  logic in_r, in_l;

`ifdef AUDIO_INPUT_SYNC_EN
  logic [1:0] sync_r, sync_l;

  // Two-stage synchronizer ahead of the input register for asynchronous sources
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_r <= 2'b00;
      sync_l <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], ext_audio_r};
      sync_l <= {sync_l[0], ext_audio_l};
    end
  end

  assign src_r = sync_r[1];
  assign src_l = sync_l[1];
`else
  assign src_r = ext_audio_r;
  assign src_l = ext_audio_l;
`endif

  // Input register: only these bits feed the accumulators
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_r <= 1'b0;
      in_l <= 1'b0;
    end else begin
      in_r <= src_r;
      in_l <= src_l;
    end
  end

  logic [DECIMATION_LOG2-1:0] phase;
  logic [DECIMATION_LOG2:0]   acc_r, acc_l;
  logic [DECIMATION_LOG2:0]   sum_r, sum_l;
  logic                       window_end;
  logic                       push;
  logic [31:0]                push_word;

  // The running sum including this cycle's bit; at window end this is the full count
  assign sum_r      = acc_r + (DECIMATION_LOG2+1)'(in_r);
  assign sum_l      = acc_l + (DECIMATION_LOG2+1)'(in_l);
  assign window_end = enable && (&phase);

  // Scale a window count to 16-bit PCM; a count of N lands on 0x10000 and is clipped
  function automatic logic [15:0] scale(input logic [DECIMATION_LOG2:0] s);
    logic [31:0] wide;
    wide = 32'(s) << SHIFT;
    return (wide > 32'h0000_FFFF) ? 16'hFFFF : wide[15:0];
  endfunction

  // Decimator: phase counter, accumulators, and the one-cycle-delayed push request
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase     <= '0;
      acc_r     <= '0;
      acc_l     <= '0;
      push      <= 1'b0;
      push_word <= '0;
    end else begin
      push <= window_end;
      if (window_end) begin
        push_word <= {scale(sum_r), scale(sum_l)};
      end
      if (!enable || window_end) begin
        phase <= '0;
        acc_r <= '0;
        acc_l <= '0;
      end else begin
        phase <= phase + PHASE_ONE;
        acc_r <= sum_r;
        acc_l <= sum_l;
      end
    end
  end

  logic [31:0]                   mem [DEPTH];
  logic [FIFO_DEPTH_IN_BITS-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_IN_BITS:0]   level_next;
  logic                          toggle, toggle_prev;
  logic                          full, pop, accept, drop;

  // A full FIFO still accepts a push when a pop frees a slot on the same edge
  assign full   = (level == FULL_LEVEL);
  assign pop    = (toggle != toggle_prev) && !empty;
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  // Next word count from the push/pop combination
  always_comb begin
    level_next = level;
    if (accept && !pop) begin
      level_next = level + LEVEL_ONE;
    end else if (pop && !accept) begin
      level_next = level - LEVEL_ONE;
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // FIFO pointers, status flags, read request edge detect and output word
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      empty       <= 1'b1;
      data        <= '0;
      overrun     <= 1'b0;
      toggle      <= 1'b0;
      toggle_prev <= 1'b0;
    end else begin
      toggle      <= req_toggle;
      toggle_prev <= toggle;
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        data   <= mem[rd_ptr];
      end
      level <= level_next;
      empty <= (level_next == '0);
      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clear) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_input.sv
// tb/tb_audio_input.sv - directed self-checking bench for audio_input (DECIMATION_LOG2=4, FIFO_DEPTH_IN_BITS=4)
module tb_audio_input;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        ext_audio_r;
  logic        ext_audio_l;
  logic        req_toggle;
  logic [31:0] data;
  logic        empty;
  logic [4:0]  level;
  logic        overrun;
  logic        overrun_clear;

  int n_checks;
  int n_fail;

`ifdef AUDIO_INPUT_SYNC_EN
  localparam logic [15:0] FIRST_FULL = 16'hD000;
`else
  localparam logic [15:0] FIRST_FULL = 16'hF000;
`endif

  audio_input #(
    .DECIMATION_LOG2(4),
    .FIFO_DEPTH_IN_BITS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .ext_audio_r(ext_audio_r),
    .ext_audio_l(ext_audio_l),
    .req_toggle(req_toggle),
    .data(data),
    .empty(empty),
    .level(level),
    .overrun(overrun),
    .overrun_clear(overrun_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset(input logic en, input logic r, input logic l);
    @(negedge clk);
    reset         = 1'b0;
    enable        = en;
    ext_audio_r   = r;
    ext_audio_l   = l;
    req_toggle    = 1'b0;
    overrun_clear = 1'b0;
    step(3);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    apply_reset(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(2);
    n_checks++; if (data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected %h", data, 32'h0); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    reset = 1'b1;
  endtask

  task automatic test_saturation;
    apply_reset(1'b1, 1'b1, 1'b1);
    step(16);
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL sat_level_window_end: got %0d expected 0", level); end
    step(1);
    n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL sat_level_first_push: got %0d expected 1", level); end
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL sat_empty_first_push: got %b expected 0", empty); end
    step(16);
    n_checks++; if (level !== 5'd2) begin n_fail++; $display("FAIL sat_level_second_push: got %0d expected 2", level); end
    enable = 1'b0;
    req_toggle = ~req_toggle;
    step(1);
    n_checks++; if (data !== 32'h0) begin n_fail++; $display("FAIL sat_pop_latency: got %h expected %h", data, 32'h0); end
    step(1);
    n_checks++; if (data !== {FIRST_FULL, FIRST_FULL}) begin n_fail++; $display("FAIL sat_first_word: got %h expected %h", data, {FIRST_FULL, FIRST_FULL}); end
    req_toggle = ~req_toggle;
    step(2);
    n_checks++; if (data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_word: got %h expected %h", data, 32'hFFFF_FFFF); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL sat_empty_drained: got %b expected 1", empty); end
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL sat_level_drained: got %0d expected 0", level); end
  endtask

  task automatic test_alternating;
    apply_reset(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ext_audio_r = ~ext_audio_r;
      step(1);
    end
    enable = 1'b1;
    for (int i = 0; i < 33; i++) begin
      ext_audio_r = ~ext_audio_r;
      step(1);
    end
    n_checks++; if (level !== 5'd2) begin n_fail++; $display("FAIL alt_level: got %0d expected 2", level); end
    enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_toggle = ~req_toggle;
      step(2);
      n_checks++; if (data !== 32'h8000_0000) begin n_fail++; $display("FAIL alt_word%0d: got %h expected %h", k, data, 32'h8000_0000); end
    end
  endtask

  task automatic test_toggle_while_empty;
    apply_reset(1'b0, 1'b0, 1'b1);
    step(4);
    req_toggle = ~req_toggle;
    step(3);
    n_checks++; if (data !== 32'h0) begin n_fail++; $display("FAIL empty_toggle_data: got %h expected %h", data, 32'h0); end
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL empty_toggle_level: got %0d expected 0", level); end
    enable = 1'b1;
    step(16);
    enable = 1'b0;
    step(1);
    n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL pending_push_level: got %0d expected 1", level); end
    n_checks++; if (data !== 32'h0) begin n_fail++; $display("FAIL toggle_not_remembered: got %h expected %h", data, 32'h0); end
    req_toggle = ~req_toggle;
    step(1);
    n_checks++; if (data !== 32'h0) begin n_fail++; $display("FAIL toggle_pop_edge1: got %h expected %h", data, 32'h0); end
    step(1);
    n_checks++; if (data !== 32'h0000_FFFF) begin n_fail++; $display("FAIL toggle_pop_word: got %h expected %h", data, 32'h0000_FFFF); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL toggle_pop_empty: got %b expected 1", empty); end
  endtask

  task automatic test_overrun;
    apply_reset(1'b0, 1'b0, 1'b1);
    step(4);
    enable = 1'b1;
    step(257);
    n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL ovr_level_full: got %0d expected 16", level); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_not_yet: got %b expected 0", overrun); end
    step(16);
    n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL ovr_level_after_drop: got %0d expected 16", level); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    overrun_clear = 1'b1;
    step(1);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
    step(15);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins: got %b expected 1", overrun); end
    step(1);
    overrun_clear = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear2: got %b expected 0", overrun); end
    step(13);
    req_toggle = ~req_toggle;
    step(1);
    n_checks++; if (data !== 32'h0) begin n_fail++; $display("FAIL full_pop_before: got %h expected %h", data, 32'h0); end
    step(1);
    n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL full_pop_push_level: got %0d expected 16", level); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL full_pop_push_overrun: got %b expected 0", overrun); end
    n_checks++; if (data !== 32'h0000_FFFF) begin n_fail++; $display("FAIL full_pop_push_data: got %h expected %h", data, 32'h0000_FFFF); end
  endtask

  task automatic test_reset_mid_window;
    apply_reset(1'b1, 1'b1, 1'b0);
    step(55);
    n_checks++; if (level !== 5'd3) begin n_fail++; $display("FAIL mid_level_before: got %0d expected 3", level); end
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    n_checks++; if (data !== 32'h0) begin n_fail++; $display("FAIL mid_reset_data: got %h expected %h", data, 32'h0); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_reset_empty: got %b expected 1", empty); end
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL mid_reset_level: got %0d expected 0", level); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL mid_reset_overrun: got %b expected 0", overrun); end
    step(16);
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL mid_partial_discarded: got %0d expected 0", level); end
    step(1);
    n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL mid_first_push: got %0d expected 1", level); end
    enable = 1'b0;
    req_toggle = ~req_toggle;
    step(2);
    n_checks++; if (data !== {FIRST_FULL, 16'h0000}) begin n_fail++; $display("FAIL mid_first_word: got %h expected %h", data, {FIRST_FULL, 16'h0000}); end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b0;
    enable        = 1'b0;
    ext_audio_r   = 1'b0;
    ext_audio_l   = 1'b0;
    req_toggle    = 1'b0;
    overrun_clear = 1'b0;
    test_reset;
    test_saturation;
    test_alternating;
    test_toggle_while_empty;
    test_overrun;
    test_reset_mid_window;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
